irq_pend_ctrl: RTL
==================

# irq_pend_ctrl

Four-channel interrupt pending/mask stage that sits directly upstream of the 4-to-2 priority encoder `enc`. It converts raw request lines into latched, maskable pending bits, drives them onto the encoder inputs `y3..y0`, and runs a request/acknowledge handshake with the consumer. The consumer acknowledges using the encoder's `{a1,a0}` result as `ack_id`.

## Interface
- `CNT_W`, default 4: width of each per-channel overflow counter. Used only with `IRQ_OVF_CNT_EN`.

Ports:
- `clk`  in  1  rising-edge clock.
- `rst_n`  in  1  asynchronous, active-low reset.
- `req`  in  4  raw request levels, synchronous to `clk`; bit i is channel i.
- `mask_we`  in  1  write strobe for the mask register.
- `mask_d`  in  4  new mask value; 1 = enabled.
- `ack`  in  1  service acknowledge from the consumer.
- `ack_id`  in  2  channel being acknowledged; driven from encoder `{a1,a0}`.
- `y3`, `y2`, `y1`, `y0`  out  1 each  masked pending bits; connect straight to encoder `y3..y0`.
- `irq`  out  1  registered interrupt request.
- `ovf_clr`  in  1  clears all overflow counters. Present only with `IRQ_OVF_CNT_EN`.
- `ovf_cnt`  out  4*CNT_W  overflow counters; channel i occupies `[i*CNT_W +: CNT_W]`. Present only with `IRQ_OVF_CNT_EN`.

## Operation
- **Edge detect.** `req_q` is `req` registered once per clock. A rising edge on channel i is `rise[i] = req[i] & ~req_q[i]`.
- **Pending register `pend[3:0]`.**
  - `rise[i]` sets `pend[i]`.
  - An accepted acknowledge clears `pend[ack_id]`.
  - If a set and a clear hit the same bit in the same cycle, set wins and the new event is kept.
- **Mask register `mask[3:0]`.** Loaded from `mask_d` when `mask_we` = 1. Masking does not clear pending bits.
- **Encoder outputs.** `{y3,y2,y1,y0} = pend & mask`, driven combinationally from registers only (no input-to-output path).
- **Handshake FSM.**
  - IDLE: `irq` = 0. Go to PEND if `|(pend & mask)`.
  - PEND: `irq` = 1.
    - If `ack` = 1, accept the acknowledge: clear `pend[ack_id]` and go to HOLD.
    - Otherwise, if `(pend & mask)` = 0 (masked off or withdrawn), go to IDLE.
  - HOLD: `irq` = 0. Stay while `ack` = 1; go to IDLE when `ack` = 0.
  - `ack` in IDLE or HOLD is ignored and clears nothing.
- **Stale `ack_id`.** An acknowledge of a channel whose pending bit is already 0 is legal: no bit changes and the FSM still moves to HOLD.
- **Reset.** Asserting `rst_n` low mid-handshake immediately returns to IDLE and clears `pend`, `req_q` and the counters.
- **Reset values.**
  - `pend` = 0, `req_q` = 0, `mask` = 4'hF.
  - FSM = IDLE, `irq` = 0, `y3..y0` = 0.
  - `ovf_cnt` = 0.

## Timing
- A `req[i]` rise sampled at edge k sets `pend[i]` at edge k. `y_i` is high in cycle k+1, so there is 1 cycle from the sampled rise to the encoder input.
- `irq` rises at edge k+1, 2 cycles after the sampled rise.
- An `ack` sampled in PEND at edge m:
  - `pend[ack_id]` and `irq` both fall at edge m.
  - The earliest next `irq` assertion is edge m+2, and only if `ack` was low at m+1.
- The encoder result is valid in the same cycle as `y*`. The consumer may sample `{a1,a0}` combinationally for `ack_id`.
- A `mask_we` at edge k affects `y*` from cycle k+1 and the FSM decision at edge k+1.
- A request held high produces only one event; it must drop and rise again to re-arm.

## Configuration
- **`IRQ_OVF_CNT_EN` defined:**
  - Channel i's counter increments on `rise[i]` when `pend[i]` is already 1 and is not cleared in the same cycle.
  - Counters saturate at 2^CNT_W−1.
  - `ovf_clr` zeroes all counters. If `ovf_clr` and an increment coincide, clear wins.
- **`IRQ_OVF_CNT_EN` not defined:**
  - The `ovf_clr` and `ovf_cnt` ports and the counter logic are absent.
  - Repeat edges on an already-pending channel are silently merged.

## Test plan
- **Basic event:** reset, then pulse `req` = 4'b0100 for one cycle → `y2` = 1 one cycle later; `irq` = 1 at the next edge; encoder gives a1a0 = 10; `ack` with `ack_id` = 2 → `y2` = 0, `irq` = 0, FSM in HOLD; `ack` low → IDLE.
- **Priority service order:** raise `req` = 4'b0110 together → `y` = 0110, encoder gives 10. Acknowledge id 2 → `y` = 0010 and `irq` re-asserts 2 cycles after `ack` drops; acknowledge id 1 → `y` = 0000 and `irq` stays low.
- **Masking:** `mask` = 4'b0111, pulse `req[3]` → `pend[3]` = 1 but `y3` = 0 and `irq` = 0. Write `mask` = 4'hF → `y3` = 1 next cycle and `irq` one cycle after that. While in PEND, mask to 0 → FSM returns to IDLE and `irq` = 0.
- **Set/clear collision:** with `pend[0]` = 1 in PEND, drive `ack_id` = 0 and a new `req[0]` rise in the same cycle → `pend[0]` stays 1 and `irq` re-asserts after HOLD exits.
- **Reset mid-handshake:** in PEND with `pend` = 4'b1001, pull `rst_n` low asynchronously → `irq`, `y*` and `pend` go to 0 immediately and `mask` returns to 4'hF.
- **With `IRQ_OVF_CNT_EN` and `CNT_W` = 4:**
  - 20 rises on `req[1]` with no ack → channel 1 counter reads 15 (saturated), `pend[1]` = 1.
  - `ovf_clr` → all counters read 0.

Source files
------------

// File: rtl/irq_pend_ctrl.sv
// Four-channel interrupt pending/mask stage feeding the 4-to-2 priority encoder.
// Optional per-channel overflow counters are enabled by defining IRQ_OVF_CNT_EN.
module irq_pend_ctrl
`ifdef IRQ_OVF_CNT_EN
#(
  parameter int CNT_W = 4
)
`endif
(
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [3:0]           req,
  input  logic                 mask_we,
  input  logic [3:0]           mask_d,
  input  logic                 ack,
  input  logic [1:0]           ack_id,
`ifdef IRQ_OVF_CNT_EN
  input  logic                 ovf_clr,
  output logic [4*CNT_W-1:0]   ovf_cnt,
`endif
  output logic                 y3,
  output logic                 y2,
  output logic                 y1,
  output logic                 y0,
  output logic                 irq
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PEND = 2'd1,
    HOLD = 2'd2
  } state_t;

  state_t      r_state;
  state_t      w_stateNext;
  logic        r_irq;
  logic [3:0]  r_reqQ;
  logic [3:0]  r_pend;
  logic [3:0]  r_mask;
  logic [3:0]  w_rise;
  logic [3:0]  w_clr;
  logic [3:0]  w_masked;
  logic        w_ackAccept;

  assign w_rise      = req & ~r_reqQ;
  assign w_masked    = r_pend & r_mask;
  assign w_ackAccept = (r_state == PEND) && ack;
  assign w_clr       = w_ackAccept ? (4'b0001 << ack_id) : 4'b0000;

  // A new rising edge beats a coincident acknowledge so the event is never lost.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_reqQ <= 4'b0000;
      r_pend <= 4'b0000;
      r_mask <= 4'hF;
    end else begin
      r_reqQ <= req;
      r_pend <= (r_pend & ~w_clr) | w_rise;
      if (mask_we) begin
        r_mask <= mask_d;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_irq   <= 1'b0;
    end else begin
      r_state <= w_stateNext;
      r_irq   <= (w_stateNext == PEND);
    end
  end

  always_comb begin
    w_stateNext = r_state;
    case (r_state)
      IDLE: begin
        if (|w_masked) begin
          w_stateNext = PEND;
        end
      end
      PEND: begin
        if (ack) begin
          w_stateNext = HOLD;
        end else if (~|w_masked) begin
          w_stateNext = IDLE;
        end
      end
      HOLD: begin
        if (!ack) begin
          w_stateNext = IDLE;
        end
      end
      default: w_stateNext = IDLE;
    endcase
  end

  assign {y3, y2, y1, y0} = w_masked;
  assign irq              = r_irq;

`ifdef IRQ_OVF_CNT_EN
  logic [CNT_W-1:0] r_ovfCnt [4];
  logic [3:0]       w_ovfInc;

  // Only a repeat edge that actually merges into a still-pending bit counts as an overflow.
  assign w_ovfInc = w_rise & r_pend & ~w_clr;

  for (genvar gi = 0; gi < 4; gi++) begin : g_ovf
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_ovfCnt[gi] <= '0;
      end else if (ovf_clr) begin
        r_ovfCnt[gi] <= '0;
      end else if (w_ovfInc[gi] && (r_ovfCnt[gi] != {CNT_W{1'b1}})) begin
        r_ovfCnt[gi] <= r_ovfCnt[gi] + {{(CNT_W-1){1'b0}}, 1'b1};
      end
    end
    assign ovf_cnt[gi*CNT_W +: CNT_W] = r_ovfCnt[gi];
  end
`endif

endmodule
